// File: rtl/l2_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : l2_writeback_buffer
// Purpose  : Single-entry victim buffer between L2 and pmem; acks evictions
//            at once, drains when idle, forwards buffered data to L2 reads.
// Revision : 1.0 - initial release
// ============================================================================
module l2_writeback_buffer #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] l2_address,
    input  logic                  l2_read,
    input  logic                  l2_write,
    input  logic [LINE_WIDTH-1:0] l2_wdata,
    output logic [LINE_WIDTH-1:0] l2_rdata,
    output logic                  l2_resp,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  wb_valid
);

    localparam int TAG_WIDTH = ADDR_WIDTH - 4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_MEM  = 3'd1;
    localparam logic [2:0] S_RD_RESP = 3'd2;
    localparam logic [2:0] S_WR_ACK  = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    localparam logic [3:0] c_offset_mask = 4'b0000;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic                  r_buf_valid;
    logic [TAG_WIDTH-1:0]  r_buf_tag;
    logic [LINE_WIDTH-1:0] r_buf_data;
    logic [LINE_WIDTH-1:0] r_rdata;

    logic [TAG_WIDTH-1:0]  w_req_tag;
    logic [ADDR_WIDTH-1:0] w_req_line_addr;
    logic                  w_match;
    logic                  w_capture;

    assign w_req_tag       = l2_address[ADDR_WIDTH-1:4];
    // Offset bits are masked so the memory only ever sees line-aligned addresses.
    assign w_req_line_addr = {w_req_tag, l2_address[3:0] & c_offset_mask};
    assign w_match         = r_buf_valid && (w_req_tag == r_buf_tag);
    // A concurrent read takes priority, so a write is only captured on its own.
    assign w_capture       = l2_write && !l2_read && (!r_buf_valid || w_match);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (l2_read) begin
                    w_next_state = w_match ? S_RD_RESP : S_RD_MEM;
                end else if (l2_write) begin
                    w_next_state = w_capture ? S_WR_ACK : S_DRAIN;
                end else if (r_buf_valid) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_RD_MEM: begin
                if (pmem_resp) begin
                    w_next_state = S_RD_RESP;
                end
            end
            S_RD_RESP: w_next_state = S_IDLE;
            S_WR_ACK:  w_next_state = S_IDLE;
            S_DRAIN: begin
                if (pmem_resp) begin
                    w_next_state = S_IDLE;
                end
            end
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        l2_rdata     = '0;
        l2_resp      = 1'b0;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        case (r_state)
            S_RD_MEM: begin
                pmem_read    = 1'b1;
                pmem_address = w_req_line_addr;
            end
            S_RD_RESP: begin
                l2_rdata = r_rdata;
                l2_resp  = 1'b1;
            end
            S_WR_ACK: l2_resp = 1'b1;
            S_DRAIN: begin
                pmem_write   = 1'b1;
                pmem_address = {r_buf_tag, 4'b0000};
            end
            default: ;
        endcase
    end

    assign pmem_wdata = r_buf_data;
    assign wb_valid   = r_buf_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
            r_rdata     <= '0;
        end else begin
            if (r_state == S_IDLE && l2_read && w_match) begin
                r_rdata <= r_buf_data;
            end
            if (r_state == S_RD_MEM && pmem_resp) begin
                r_rdata <= pmem_rdata;
            end
            // A matching write overwrites the buffered line in place.
            if (r_state == S_IDLE && w_capture) begin
                r_buf_valid <= 1'b1;
                r_buf_tag   <= w_req_tag;
                r_buf_data  <= l2_wdata;
            end
            if (r_state == S_DRAIN && pmem_resp) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l2_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_writeback_buffer
// Purpose  : Directed self-checking bench for l2_writeback_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_writeback_buffer;

    localparam logic [127:0] c_d1 = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
    localparam logic [127:0] c_d2 = 128'hAAAA_0000_BBBB_0000_CCCC_0000_DDDD_0000;
    localparam logic [127:0] c_d3 = 128'h3333_5670_3333_5670_3333_5670_3333_5670;
    localparam logic [127:0] c_d4 = 128'h4444_DEAD_4444_BEEF_4444_CAFE_4444_F00D;
    localparam logic [127:0] c_d5 = 128'h5555_0123_4567_89AB_CDEF_5555_0000_FFFF;

    logic         clk;
    logic         reset;
    logic [15:0]  l2_address;
    logic         l2_read;
    logic         l2_write;
    logic [127:0] l2_wdata;
    logic [127:0] l2_rdata;
    logic         l2_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         wb_valid;

    int n_pass;
    int n_total;

    l2_writeback_buffer #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
        .clk(clk), .reset(reset),
        .l2_address(l2_address), .l2_read(l2_read), .l2_write(l2_write),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .wb_valid(wb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Steps negedges until the requested pmem strobe is high, bounded.
    task automatic wait_pmem(input bit want_write, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((want_write ? pmem_write : pmem_read) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Memory holds the strobe for 'delay' more cycles, then pulses resp once.
    task automatic mem_respond(input logic [127:0] d, input int delay);
        repeat (delay) @(negedge clk);
        pmem_rdata = d;
        pmem_resp  = 1'b1;
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
    endtask

    // Writes a line into an empty or matching buffer; returns on the ack edge.
    task automatic write_line(input logic [15:0] a, input logic [127:0] d);
        l2_address = a;
        l2_wdata   = d;
        l2_write   = 1'b1;
        @(negedge clk);
        n_total++;
        if (l2_resp !== 1'b1) $display("FAIL write_ack: l2_resp=%b expected 1", l2_resp);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({l2_resp, pmem_read, pmem_write, wb_valid} !== 4'b0000)
            $display("FAIL reset_strobes: resp/rd/wr/wbv=%b expected 0000",
                     {l2_resp, pmem_read, pmem_write, wb_valid});
        else n_pass++;
        n_total++;
        if (l2_rdata !== 128'h0 || pmem_address !== 16'h0 || pmem_wdata !== 128'h0)
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h expected zeros",
                     l2_rdata, pmem_address, pmem_wdata);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_write_empty();
        bit ok;
        write_line(16'h1234, c_d1);
        n_total++;
        if (wb_valid !== 1'b1) $display("FAIL wr_empty_valid: wb_valid=%b expected 1", wb_valid);
        else n_pass++;
        l2_write = 1'b0;
        @(negedge clk);
        n_total++;
        if (l2_resp !== 1'b0) $display("FAIL wr_empty_pulse: l2_resp=%b expected 0", l2_resp);
        else n_pass++;
        wait_pmem(1'b1, ok);
        n_total++;
        if (!ok || pmem_address !== 16'h1230 || pmem_wdata !== c_d1 || pmem_read !== 1'b0)
            $display("FAIL wr_empty_drain: ok=%b addr=%h wdata=%h rd=%b expected 1 1230 %h 0",
                     ok, pmem_address, pmem_wdata, pmem_read, c_d1);
        else n_pass++;
        mem_respond('0, 4);
        n_total++;
        if (wb_valid !== 1'b0 || pmem_write !== 1'b0)
            $display("FAIL wr_empty_done: wb_valid=%b pmem_write=%b expected 0 0", wb_valid, pmem_write);
        else n_pass++;
    endtask

    task automatic test_read_hit_then_miss();
        bit ok;
        write_line(16'h1230, c_d1);
        l2_write   = 1'b0;
        l2_read    = 1'b1;
        l2_address = 16'h1238;
        @(negedge clk);
        n_total++;
        if (pmem_read !== 1'b0 || l2_resp !== 1'b0)
            $display("FAIL hit_idle: pmem_read=%b l2_resp=%b expected 0 0", pmem_read, l2_resp);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (l2_resp !== 1'b1 || l2_rdata !== c_d1 || pmem_read !== 1'b0)
            $display("FAIL hit_resp: resp=%b rdata=%h pmem_read=%b expected 1 %h 0",
                     l2_resp, l2_rdata, pmem_read, c_d1);
        else n_pass++;
        l2_address = 16'h4000;
        @(negedge clk);
        wait_pmem(1'b0, ok);
        n_total++;
        if (!ok || pmem_address !== 16'h4000 || pmem_write !== 1'b0 || wb_valid !== 1'b1)
            $display("FAIL miss_req: ok=%b addr=%h wr=%b wbv=%b expected 1 4000 0 1",
                     ok, pmem_address, pmem_write, wb_valid);
        else n_pass++;
        mem_respond(c_d2, 2);
        n_total++;
        if (l2_resp !== 1'b1 || l2_rdata !== c_d2)
            $display("FAIL miss_resp: resp=%b rdata=%h expected 1 %h", l2_resp, l2_rdata, c_d2);
        else n_pass++;
        l2_read = 1'b0;
        wait_pmem(1'b1, ok);
        n_total++;
        if (!ok || pmem_address !== 16'h1230 || pmem_wdata !== c_d1)
            $display("FAIL miss_drain: ok=%b addr=%h wdata=%h expected 1 1230 %h",
                     ok, pmem_address, pmem_wdata, c_d1);
        else n_pass++;
        mem_respond('0, 1);
        n_total++;
        if (wb_valid !== 1'b0) $display("FAIL miss_drain_done: wb_valid=%b expected 0", wb_valid);
        else n_pass++;
    endtask

    task automatic test_write_full();
        bit ok;
        write_line(16'h1230, c_d1);
        l2_address = 16'h5670;
        l2_wdata   = c_d3;
        @(negedge clk);
        wait_pmem(1'b1, ok);
        n_total++;
        if (!ok || pmem_address !== 16'h1230 || pmem_wdata !== c_d1 || l2_resp !== 1'b0)
            $display("FAIL full_drain: ok=%b addr=%h wdata=%h resp=%b expected 1 1230 %h 0",
                     ok, pmem_address, pmem_wdata, l2_resp, c_d1);
        else n_pass++;
        mem_respond('0, 2);
        n_total++;
        if (l2_resp !== 1'b0 || wb_valid !== 1'b0 || pmem_write !== 1'b0)
            $display("FAIL full_m1: resp=%b wbv=%b wr=%b expected 0 0 0", l2_resp, wb_valid, pmem_write);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (l2_resp !== 1'b1 || wb_valid !== 1'b1)
            $display("FAIL full_ack: resp=%b wbv=%b expected 1 1", l2_resp, wb_valid);
        else n_pass++;
        l2_write = 1'b0;
        wait_pmem(1'b1, ok);
        n_total++;
        if (!ok || pmem_address !== 16'h5670 || pmem_wdata !== c_d3)
            $display("FAIL full_drain2: ok=%b addr=%h wdata=%h expected 1 5670 %h",
                     ok, pmem_address, pmem_wdata, c_d3);
        else n_pass++;
        mem_respond('0, 0);
    endtask

    task automatic test_write_merge();
        bit ok;
        write_line(16'h1230, c_d1);
        l2_wdata = c_d4;
        @(negedge clk);
        n_total++;
        if (pmem_write !== 1'b0 || l2_resp !== 1'b0)
            $display("FAIL merge_idle: wr=%b resp=%b expected 0 0", pmem_write, l2_resp);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (l2_resp !== 1'b1 || pmem_write !== 1'b0 || wb_valid !== 1'b1)
            $display("FAIL merge_ack: resp=%b wr=%b wbv=%b expected 1 0 1", l2_resp, pmem_write, wb_valid);
        else n_pass++;
        l2_write = 1'b0;
        wait_pmem(1'b1, ok);
        n_total++;
        if (!ok || pmem_address !== 16'h1230 || pmem_wdata !== c_d4)
            $display("FAIL merge_drain: ok=%b addr=%h wdata=%h expected 1 1230 %h",
                     ok, pmem_address, pmem_wdata, c_d4);
        else n_pass++;
        mem_respond('0, 0);
    endtask

    task automatic test_reset_drain();
        bit ok;
        write_line(16'h1230, c_d1);
        l2_write = 1'b0;
        wait_pmem(1'b1, ok);
        n_total++;
        if (!ok) $display("FAIL rst_drain_start: pmem_write=%b expected 1", pmem_write);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if (pmem_write !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL rst_drain: wr=%b wbv=%b expected 0 0", pmem_write, wb_valid);
        else n_pass++;
        reset      = 1'b0;
        l2_read    = 1'b1;
        l2_address = 16'h1230;
        wait_pmem(1'b0, ok);
        n_total++;
        if (!ok || pmem_address !== 16'h1230)
            $display("FAIL rst_read_req: ok=%b addr=%h expected 1 1230", ok, pmem_address);
        else n_pass++;
        mem_respond(c_d5, 1);
        n_total++;
        if (l2_resp !== 1'b1 || l2_rdata !== c_d5)
            $display("FAIL rst_read_resp: resp=%b rdata=%h expected 1 %h", l2_resp, l2_rdata, c_d5);
        else n_pass++;
        l2_read = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (pmem_write !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL rst_no_drain: wr=%b wbv=%b expected 0 0", pmem_write, wb_valid);
        else n_pass++;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        reset      = 1'b1;
        l2_address = '0;
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        l2_wdata   = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        test_reset();
        test_write_empty();
        test_read_hit_then_miss();
        test_write_full();
        test_write_merge();
        test_reset_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/l2_writeback_buffer.md
Name: l2_writeback_buffer

Overview:
- Single-entry victim/write-back buffer between the L2 cache controller (upstream) and physical memory (downstream).
- Accepts an evicted dirty line from L2 in one cycle and acks immediately, so L2 can go straight to its line fetch.
- Drains the line to pmem opportunistically, when no L2 request is pending.
- Serves L2 line reads, forwarding from the buffer on an address match and passing misses through to pmem.

Parameters:
- ADDR_WIDTH, 16, byte address width of the L2 and pmem address buses.
- LINE_WIDTH, 128, cache line width in bits (16-byte line; offset bits [3:0]).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- l2_address  in  ADDR_WIDTH  line address from L2; bits [3:0] ignored.
- l2_read  in  1  line read request; held high until l2_resp.
- l2_write  in  1  line write-back request; held high until l2_resp.
- l2_wdata  in  LINE_WIDTH  line to write back.
- l2_rdata  out  LINE_WIDTH  read data; valid while l2_resp=1.
- l2_resp  out  1  one-cycle completion pulse.
- pmem_address  out  ADDR_WIDTH  line address to memory; bits [3:0] always 0.
- pmem_read  out  1  memory line read; held until pmem_resp.
- pmem_write  out  1  memory line write; held until pmem_resp.
- pmem_wdata  out  LINE_WIDTH  write data; always the buffered line.
- pmem_rdata  in  LINE_WIDTH  memory read data; valid with pmem_resp.
- pmem_resp  in  1  memory completion pulse.
- wb_valid  out  1  buffer holds an undrained line.

Behaviour:
- Storage:
  - buf_valid, buf_tag = address bits [ADDR_WIDTH-1:4], buf_data, rdata_reg.
  - "match" means buf_valid && l2_address[ADDR_WIDTH-1:4] == buf_tag.
- Reset values: state IDLE; buf_valid=0; all outputs 0, including l2_rdata and pmem_address.
- States: IDLE, RD_MEM, RD_RESP, WR_ACK, DRAIN. l2_resp=1 only in RD_RESP and WR_ACK (Moore, exactly one cycle).
- IDLE decision at cycle T, in priority order:
  - l2_read && match: rdata_reg<=buf_data, go to RD_RESP. l2_resp at T+1; no pmem access.
  - l2_read && !match: go to RD_MEM.
  - l2_write && (!buf_valid || match): capture tag/data, buf_valid<=1, go to WR_ACK. l2_resp at T+1; a match overwrites in place.
  - l2_write && buf_valid && !match: go to DRAIN. The write is served on the IDLE pass after the drain completes.
  - No request && buf_valid: go to DRAIN.
  - Otherwise: stay in IDLE.
- l2_read and l2_write asserted together: protocol violation. Read wins and the write is ignored until resubmitted.
- RD_MEM:
  - pmem_read=1, pmem_address={l2_address[ADDR_WIDTH-1:4],4'b0}.
  - On pmem_resp: rdata_reg<=pmem_rdata, go to RD_RESP.
  - Miss read latency: resp at M+1, where M is the pmem_resp cycle.
- RD_RESP and WR_ACK: drive l2_rdata=rdata_reg (RD_RESP), l2_resp=1, return to IDLE.
- DRAIN:
  - pmem_write=1, pmem_address={buf_tag,4'b0}, pmem_wdata=buf_data.
  - On pmem_resp: buf_valid<=0, go to IDLE.
  - A drain in progress is never aborted; L2 requests wait.
  - Full-buffer write latency: drain done at M, IDLE at M+1, capture, ack at M+2.
- pmem_read and pmem_write are never high together. pmem_resp is ignored in IDLE, RD_RESP and WR_ACK.
- Reset mid-drain or mid-read: next cycle state=IDLE, buf_valid=0, pmem strobes low. The buffered line is discarded.
- After a write ack, L2 must not see stale data: a read to the same line hits the buffer until drain completes.

Test Plan:
- Empty buffer, l2_write addr 0x1234 data D1 → l2_resp on next cycle, wb_valid=1. Idle afterwards → pmem_write to 0x1230 with D1. Memory resp after 5 cycles → wb_valid=0.
- Buffer holds 0x1230/D1; l2_read 0x1238 → l2_resp next cycle with l2_rdata=D1, pmem_read never asserted.
- Buffer holds 0x1230; l2_read 0x4000 issued the cycle after the write ack → pmem_read 0x4000 before any drain. Memory returns D2 → l2_rdata=D2 one cycle after pmem_resp; drain of 0x1230 follows.
- Buffer holds 0x1230; l2_write 0x5670/D3 → DRAIN of 0x1230 first, then capture 0x5670, resp 2 cycles after pmem_resp. Next drain writes D3 to 0x5670.
- Buffer holds 0x1230/D1; l2_write 0x1230/D4 → ack next cycle, no pmem traffic, later drain writes D4.
- Reset asserted during DRAIN → pmem_write=0 and wb_valid=0 on the next cycle; a subsequent l2_read 0x1230 goes to pmem.
